// File: rtl/sync_arith_pkg.sv
// Shared types and constants for the synchronous ALU operand loader and its ALU.
// Opcodes and status bit positions are common to both blocks.
package sync_arith_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CHECK  = 3'd3,
        WAIT   = 3'd4
    } state_e;

    localparam logic [3:0] MARKER_DEFAULT = 4'hA;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;

    localparam int ERROR      = 3;
    localparam int NOT_EVEN_1 = 2;
    localparam int ZEROS      = 1;
    localparam int OVERFLOW   = 0;

    // Running frame checksum: XOR of every byte seen so far.
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/sync_arith_loader_if.sv
// Byte-stream input and ALU-facing output bundle of the operand loader.
// master = stream producer / ALU consumer side, slave = the loader itself.
interface sync_arith_loader_if #(
    parameter int M = 32
);
    logic [7:0]   i_data;
    logic         i_valid;
    logic         o_ready;
    logic         i_abort;
    logic [M-1:0] oarg_A;
    logic [M-1:0] oarg_B;
    logic [3:0]   oop;
    logic         o_issue;
    logic         o_frame_err;
    logic [7:0]   o_frame_cnt;
    logic         o_busy;

    modport master (
        output i_data, i_valid, i_abort,
        input  o_ready, oarg_A, oarg_B, oop, o_issue, o_frame_err, o_frame_cnt, o_busy
    );

    modport slave (
        input  i_data, i_valid, i_abort,
        output o_ready, oarg_A, oarg_B, oop, o_issue, o_frame_err, o_frame_cnt, o_busy
    );
endinterface

// File: rtl/sync_arith_byte_shifter.sv
// Shadow register assembled one byte at a time; the byte lane is picked by idx.
// Lanes not addressed keep their value, so no clear is needed between frames.
module sync_arith_byte_shifter #(
    parameter int M = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [$clog2(M/8):0]  idx,
    input  logic [7:0]            din,
    output logic [M-1:0]          shadow
);
    localparam int N     = M / 8;
    localparam int IDX_W = $clog2(M / 8) + 1;

    logic [M-1:0] shadow_r;

    // Write the addressed byte lane on each accepted operand byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= '0;
        end else if (we) begin
            for (int i = 0; i < N; i++) begin
                if (idx == IDX_W'(i)) begin
                    shadow_r[8*i +: 8] <= din;
                end
            end
        end
    end

    assign shadow = shadow_r;

endmodule

// File: rtl/sync_arith_loader.sv
// Operand loader: assembles {marker,op}, A, B and an XOR checksum from a byte stream
// and hands registered operands to the ALU with a one-cycle issue strobe.
module sync_arith_loader
    import sync_arith_pkg::*;
#(
    parameter int         M      = 32,
    parameter logic [3:0] MARKER = MARKER_DEFAULT
) (
    input  logic                clk,
    input  logic                i_reset,
    sync_arith_loader_if.slave  bus
);
    localparam int                N        = M / 8;
    localparam int                CNT_W    = $clog2(N) + 1;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N - 1);

    state_e           state_r;
    state_e           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [7:0]       acc_r;
    logic [7:0]       acc_s;
    logic [3:0]       op_shadow_r;
    logic [3:0]       op_shadow_s;

    logic             accept_s;
    logic             load_a_s;
    logic             load_b_s;
    logic             commit_s;
    logic             err_s;

    logic [M-1:0]     shadow_a_s;
    logic [M-1:0]     shadow_b_s;

    logic             ready_r;
    logic             busy_r;
    logic             issue_r;
    logic             err_r;
    logic [M-1:0]     arg_a_r;
    logic [M-1:0]     arg_b_r;
    logic [3:0]       op_r;
    logic [7:0]       frame_cnt_r;

    assign accept_s = bus.i_valid & ready_r;

    sync_arith_byte_shifter #(.M(M)) u_shift_a (
        .clk    (clk),
        .rst_n  (i_reset),
        .we     (load_a_s),
        .idx    (cnt_r),
        .din    (bus.i_data),
        .shadow (shadow_a_s)
    );

    sync_arith_byte_shifter #(.M(M)) u_shift_b (
        .clk    (clk),
        .rst_n  (i_reset),
        .we     (load_b_s),
        .idx    (cnt_r),
        .din    (bus.i_data),
        .shadow (shadow_b_s)
    );

    // Next-state, byte bookkeeping and strobe decode; abort overrides any accept
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        acc_s       = acc_r;
        op_shadow_s = op_shadow_r;
        load_a_s    = 1'b0;
        load_b_s    = 1'b0;
        commit_s    = 1'b0;
        err_s       = 1'b0;

        if (bus.i_abort) begin
            state_s = IDLE;
            cnt_s   = '0;
            acc_s   = 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (bus.i_data[7:4] == MARKER) begin
                            op_shadow_s = bus.i_data[3:0];
                            acc_s       = bus.i_data;
                            cnt_s       = '0;
                            state_s     = LOAD_A;
                        end else begin
                            err_s = 1'b1;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                LOAD_A: begin
                    if (accept_s) begin
                        load_a_s = 1'b1;
                        acc_s    = csum_step(acc_r, bus.i_data);
                        if (cnt_r == LAST_IDX) begin
                            cnt_s   = '0;
                            state_s = LOAD_B;
                        end else begin
                            cnt_s = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_s = LOAD_A;
                    end
                end
                LOAD_B: begin
                    if (accept_s) begin
                        load_b_s = 1'b1;
                        acc_s    = csum_step(acc_r, bus.i_data);
                        if (cnt_r == LAST_IDX) begin
                            cnt_s   = '0;
                            state_s = CHECK;
                        end else begin
                            cnt_s = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_s = LOAD_B;
                    end
                end
                CHECK: begin
                    if (accept_s) begin
                        cnt_s = '0;
                        acc_s = 8'h00;
                        if (bus.i_data == acc_r) begin
                            commit_s = 1'b1;
                            state_s  = WAIT;
                        end else begin
                            err_s   = 1'b1;
                            state_s = IDLE;
                        end
                    end else begin
                        state_s = CHECK;
                    end
                end
                WAIT: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = '0;
                    acc_s   = 8'h00;
                end
            endcase
        end
    end

    // FSM state and frame-assembly bookkeeping
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            acc_r       <= 8'h00;
            op_shadow_r <= 4'h0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            acc_r       <= acc_s;
            op_shadow_r <= op_shadow_s;
        end
    end

    // Handshake/status flags follow the next state so they come straight from flops
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            issue_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            ready_r <= (state_s != WAIT);
            busy_r  <= (state_s != IDLE);
            issue_r <= commit_s;
            err_r   <= err_s;
        end
    end

    // ALU-facing results only move on a frame whose checksum matched
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            arg_a_r     <= '0;
            arg_b_r     <= '0;
            op_r        <= 4'h0;
            frame_cnt_r <= 8'h00;
        end else if (commit_s) begin
            arg_a_r     <= shadow_a_s;
            arg_b_r     <= shadow_b_s;
            op_r        <= op_shadow_r;
            frame_cnt_r <= frame_cnt_r + 8'd1;
        end else begin
            arg_a_r     <= arg_a_r;
            arg_b_r     <= arg_b_r;
            op_r        <= op_r;
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign bus.o_ready     = ready_r;
    assign bus.o_busy      = busy_r;
    assign bus.o_issue     = issue_r;
    assign bus.o_frame_err = err_r;
    assign bus.oarg_A      = arg_a_r;
    assign bus.oarg_B      = arg_b_r;
    assign bus.oop         = op_r;
    assign bus.o_frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_sync_arith_loader.sv
// Bench for sync_arith_loader: frame table plus hand-written abort/reset/back-to-back
// sequences; good frames push expected ALU outputs to a scoreboard popped on o_issue.
module tb_sync_arith_loader;
    import sync_arith_pkg::*;

    localparam int M = 32;
    localparam int N = M / 8;

    logic clk     = 1'b0;
    logic i_reset = 1'b0;

    always #5 clk = ~clk;

    sync_arith_loader_if #(.M(M)) bus ();

    sync_arith_loader #(.M(M), .MARKER(4'hA)) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    typedef struct {
        logic [M-1:0] a;
        logic [M-1:0] b;
        logic [3:0]   op;
        logic [7:0]   cnt;
    } exp_t;

    typedef struct {
        logic [7:0]   cmd;
        logic [M-1:0] a;
        logic [M-1:0] b;
        logic         ck_given;
        logic [7:0]   ck;
        logic         exp_issue;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[6];

    int tests_run    = 0;
    int tests_failed = 0;
    int issue_seen   = 0;
    int err_seen     = 0;
    int ready_low    = 0;

    logic [7:0]   exp_cnt = 8'd0;
    logic [M-1:0] last_a  = '0;
    logic [M-1:0] last_b  = '0;
    logic [3:0]   last_op = 4'd0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Output monitor: pops the scoreboard on every issue strobe
    always @(negedge clk) begin
        if (i_reset) begin
            if (!bus.o_ready) ready_low++;
            if (bus.o_frame_err) err_seen++;
            if (bus.o_issue) begin
                issue_seen++;
                check("issue_with_err", 64'(bus.o_frame_err), 64'(1'b0));
                check("ready_during_issue", 64'(bus.o_ready), 64'(1'b0));
                if (sb_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_issue: got issue with oop=0x%0h expected no issue", bus.oop);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("oarg_A", 64'(bus.oarg_A), 64'(mon_e.a));
                    check("oarg_B", 64'(bus.oarg_B), 64'(mon_e.b));
                    check("oop", 64'(bus.oop), 64'(mon_e.op));
                    check("o_frame_cnt", 64'(bus.o_frame_cnt), 64'(mon_e.cnt));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bus.i_data  = b;
        bus.i_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.o_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        tests_run++;
        tests_failed++;
        $display("FAIL accept_timeout: byte 0x%0h not accepted within 20 cycles", b);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [M-1:0] a, input logic [M-1:0] b,
                              input logic ck_given, input logic [7:0] ck_in, input logic expect_issue);
        logic [7:0] x;
        exp_t       e;
        x = cmd;
        for (int i = 0; i < N; i++) x = x ^ a[8*i +: 8];
        for (int i = 0; i < N; i++) x = x ^ b[8*i +: 8];
        if (ck_given) x = ck_in;
        if (expect_issue) begin
            exp_cnt = exp_cnt + 8'd1;
            e.a = a; e.b = b; e.op = cmd[3:0]; e.cnt = exp_cnt;
            sb_q.push_back(e);
            last_a = a; last_b = b; last_op = cmd[3:0];
        end
        send_byte(cmd);
        check("busy_after_cmd", 64'(bus.o_busy), 64'(1'b1));
        for (int i = 0; i < N; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < N; i++) send_byte(b[8*i +: 8]);
        send_byte(x);
    endtask

    // Called right after the checksum byte is accepted
    task automatic post_checks(input logic exp_issue);
        check("issue_strobe", 64'(bus.o_issue), 64'(exp_issue));
        check("err_strobe", 64'(bus.o_frame_err), 64'(!exp_issue));
        check("ready_in_strobe", 64'(bus.o_ready), 64'(!exp_issue));
        @(posedge clk); #1;
        check("issue_one_cycle", 64'(bus.o_issue), 64'(1'b0));
        check("err_one_cycle", 64'(bus.o_frame_err), 64'(1'b0));
        check("ready_after", 64'(bus.o_ready), 64'(1'b1));
        check("hold_A", 64'(bus.oarg_A), 64'(last_a));
        check("hold_B", 64'(bus.oarg_B), 64'(last_b));
        check("hold_op", 64'(bus.oop), 64'(last_op));
        check("hold_cnt", 64'(bus.o_frame_cnt), 64'(exp_cnt));
        check("busy_after", 64'(bus.o_busy), 64'(1'b0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, i0, r0;
        bus.i_data  = 8'h00;
        bus.i_valid = 1'b0;
        bus.i_abort = 1'b0;

        vecs[0] = '{8'hA2, 32'h0000_0064, 32'hFFFF_FFFA, 1'b1, 8'hC3, 1'b1};
        vecs[1] = '{8'hA2, 32'h0000_0064, 32'hFFFF_FFFA, 1'b1, 8'h00, 1'b0};
        vecs[2] = '{8'hA3, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 8'h00, 1'b1};
        vecs[3] = '{8'hA0, 32'h0000_0000, 32'h0000_0000, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{8'hA1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 8'hA1, 1'b0};
        vecs[5] = '{8'hAF, 32'h8000_0001, 32'h7FFF_FFFE, 1'b0, 8'h00, 1'b1};

        // Reset state
        #12;
        check("rst_A", 64'(bus.oarg_A), 64'(0));
        check("rst_B", 64'(bus.oarg_B), 64'(0));
        check("rst_op", 64'(bus.oop), 64'(0));
        check("rst_issue", 64'(bus.o_issue), 64'(0));
        check("rst_err", 64'(bus.o_frame_err), 64'(0));
        check("rst_cnt", 64'(bus.o_frame_cnt), 64'(0));
        check("rst_busy", 64'(bus.o_busy), 64'(0));
        check("rst_ready", 64'(bus.o_ready), 64'(0));
        @(posedge clk); #1;
        i_reset = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 64'(bus.o_ready), 64'(1));
        check("busy_after_rst", 64'(bus.o_busy), 64'(0));

        // Frame table
        for (int v = 0; v < 6; v++) begin
            e0 = err_seen;
            send_frame(vecs[v].cmd, vecs[v].a, vecs[v].b, vecs[v].ck_given, vecs[v].ck, vecs[v].exp_issue);
            bus.i_valid = 1'b0;
            post_checks(vecs[v].exp_issue);
            check("err_count_frame", 64'(err_seen - e0), 64'(!vecs[v].exp_issue));
        end

        // Wrong marker in IDLE, then a normal frame
        send_byte(8'h52);
        bus.i_valid = 1'b0;
        check("bad_marker_err", 64'(bus.o_frame_err), 64'(1));
        check("bad_marker_idle", 64'(bus.o_busy), 64'(0));
        check("bad_marker_ready", 64'(bus.o_ready), 64'(1));
        @(posedge clk); #1;
        check("bad_marker_err_1cyc", 64'(bus.o_frame_err), 64'(0));
        send_frame(8'hA3, 32'hCAFE_0001, 32'h0BAD_F00D, 1'b0, 8'h00, 1'b1);
        bus.i_valid = 1'b0;
        post_checks(1'b1);

        // Abort a partial frame
        send_byte(8'hA2);
        send_byte(8'h64);
        send_byte(8'h00);
        bus.i_valid = 1'b0;
        bus.i_abort = 1'b1;
        e0 = err_seen;
        i0 = issue_seen;
        @(posedge clk); #1;
        bus.i_abort = 1'b0;
        check("abort_idle", 64'(bus.o_busy), 64'(0));
        check("abort_no_err", 64'(bus.o_frame_err), 64'(0));
        send_frame(8'hA1, 32'h0000_0007, 32'h0000_0003, 1'b0, 8'h00, 1'b1);
        bus.i_valid = 1'b0;
        post_checks(1'b1);
        check("abort_issue_count", 64'(issue_seen - i0), 64'(1));
        check("abort_err_count", 64'(err_seen - e0), 64'(0));

        // Reset mid-frame
        send_byte(8'hA2);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        bus.i_valid = 1'b0;
        i_reset = 1'b0;
        #2;
        check("midrst_A", 64'(bus.oarg_A), 64'(0));
        check("midrst_B", 64'(bus.oarg_B), 64'(0));
        check("midrst_op", 64'(bus.oop), 64'(0));
        check("midrst_cnt", 64'(bus.o_frame_cnt), 64'(0));
        check("midrst_busy", 64'(bus.o_busy), 64'(0));
        check("midrst_ready", 64'(bus.o_ready), 64'(0));
        exp_cnt = 8'd0;
        last_a  = '0;
        last_b  = '0;
        last_op = 4'd0;
        @(posedge clk); #1;
        i_reset = 1'b1;
        @(posedge clk); #1;
        send_frame(8'hA2, 32'h0000_0064, 32'hFFFF_FFFA, 1'b0, 8'h00, 1'b1);
        bus.i_valid = 1'b0;
        post_checks(1'b1);

        // 256 back-to-back frames with i_valid held high
        r0 = ready_low;
        i0 = issue_seen;
        for (int f = 0; f < 256; f++) begin
            send_frame({4'hA, 4'(f % 4)}, 32'($urandom), 32'($urandom), 1'b0, 8'h00, 1'b1);
        end
        bus.i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("b2b_ready_low", 64'(ready_low - r0), 64'(256));
        check("b2b_issues", 64'(issue_seen - i0), 64'(256));
        check("b2b_cnt", 64'(bus.o_frame_cnt), 64'(exp_cnt));
        check("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
